// File: rtl/fixed_ieee_pkg.sv
// Shared types and constants for the Q16.16 to IEEE-754 single converter.
package fixed_ieee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        ROUND,
        OUT
    } state_t;

    localparam int IEEE_BIAS = 127;
    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;
    localparam int NUM_CH    = 3;

endpackage

// File: rtl/fx_round_pack.sv
// Combinational rounder/packer: normalised magnitude (bit 31 set) -> IEEE-754 word.
// FIXED_TO_IEEE3_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fx_round_pack
    import fixed_ieee_pkg::*;
(
    input  logic [31:0]      i_mag,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_zero,
    output logic [31:0]      o_word
);

    logic [MANT_W-1:0] w_mant;
    logic [MANT_W-1:0] w_mant_out;
    logic [EXP_W-1:0]  w_exp_out;

    assign w_mant = i_mag[30:8];

`ifdef FIXED_TO_IEEE3_RNE_EN
    logic          w_guard;
    logic          w_sticky;
    logic          w_inc;
    logic [MANT_W:0] w_mant_sum;
    logic          w_unused;

    assign w_guard    = i_mag[7];
    assign w_sticky   = |i_mag[6:0];
    assign w_inc      = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_inc};
    // A carry out of the mantissa leaves its lower bits at zero and bumps the exponent.
    assign w_mant_out = w_mant_sum[MANT_W-1:0];
    assign w_exp_out  = w_mant_sum[MANT_W] ? i_exp + 8'd1 : i_exp;
    assign w_unused   = i_mag[31];
`else
    logic w_unused;

    assign w_mant_out = w_mant;
    assign w_exp_out  = i_exp;
    assign w_unused   = ^{i_mag[31], i_mag[7:0]};
`endif

    // Zero has no leading one, so it bypasses packing and is forced to +0.
    always_comb begin
        o_word = 32'h0000_0000;
        if (!i_zero) begin
            o_word = {i_sign, w_exp_out, w_mant_out};
        end
    end

endmodule

// File: rtl/fixed_to_ieee3.sv
// Captures three signed Q16.16 results and converts them one at a time to IEEE-754
// single precision, presenting all three words under a stb/ack handshake.
// Optional macro: FIXED_TO_IEEE3_RNE_EN (round-to-nearest-even; default truncates).
//
// state | meaning
// IDLE  | waiting for i_in_stb, o_in_ack high
// ABS   | sign/magnitude of current channel, exponent preset
// NORM  | shift left until magnitude bit 31 is set
// ROUND | round, pack, store word, advance channel
// OUT   | o_out_stb high until i_out_ack
module fixed_to_ieee3
    import fixed_ieee_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_epx,
    input  logic [31:0] i_sinhx,
    input  logic [31:0] i_coshx,
    input  logic        i_in_stb,
    output logic        o_in_ack,
    output logic [31:0] o_ieee_epx,
    output logic [31:0] o_ieee_sinhx,
    output logic [31:0] o_ieee_coshx,
    output logic        o_out_stb,
    input  logic        i_out_ack
);

    localparam logic [EXP_W-1:0] EXP_START = EXP_W'(31 + IEEE_BIAS - FRAC_BITS);
    localparam logic [1:0]       LAST_CH   = 2'(NUM_CH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ch;
    logic [31:0]      r_in  [NUM_CH];
    logic [31:0]      r_out [NUM_CH];
    logic [31:0]      r_mag;
    logic             r_sign;
    logic             r_zero;
    logic [EXP_W-1:0] r_exp;
    logic [31:0]      w_sel;
    logic [31:0]      w_abs;
    logic [31:0]      w_word;

    assign w_sel = r_in[r_ch];
    // Negating 0x80000000 wraps back to 0x80000000, which is the wanted unsigned magnitude.
    assign w_abs = w_sel[31] ? (~w_sel + 32'd1) : w_sel;

    fx_round_pack u_round_pack (
        .i_mag  (r_mag),
        .i_sign (r_sign),
        .i_exp  (r_exp),
        .i_zero (r_zero),
        .o_word (w_word)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_in_stb) w_state_nxt = ABS;
            ABS:     if (w_abs == 32'd0 || w_abs[31]) w_state_nxt = ROUND;
                     else w_state_nxt = NORM;
            NORM:    if (r_mag[30]) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = (r_ch == LAST_CH) ? OUT : ABS;
            OUT:     if (i_out_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture, normalisation datapath and per-channel result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch   <= 2'd0;
            r_mag  <= 32'd0;
            r_sign <= 1'b0;
            r_zero <= 1'b0;
            r_exp  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_in[i]  <= 32'd0;
                r_out[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_stb) begin
                        r_in[0] <= i_epx;
                        r_in[1] <= i_sinhx;
                        r_in[2] <= i_coshx;
                        r_ch    <= 2'd0;
                    end
                end
                ABS: begin
                    r_mag  <= w_abs;
                    r_sign <= w_sel[31];
                    r_zero <= (w_abs == 32'd0);
                    r_exp  <= EXP_START;
                end
                NORM: begin
                    r_mag <= {r_mag[30:0], 1'b0};
                    r_exp <= r_exp - 8'd1;
                end
                ROUND: begin
                    r_out[r_ch] <= w_word;
                    r_ch        <= (r_ch == LAST_CH) ? 2'd0 : r_ch + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_in_ack     = (r_state == IDLE);
    assign o_out_stb    = (r_state == OUT);
    assign o_ieee_epx   = r_out[0];
    assign o_ieee_sinhx = r_out[1];
    assign o_ieee_coshx = r_out[2];

endmodule

// File: tb/tb_fixed_to_ieee3.sv
// Directed plus random checks of fixed_to_ieee3 against an arithmetic reference model.
module tb_fixed_to_ieee3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] epx = 32'd0;
    logic [31:0] sinhx = 32'd0;
    logic [31:0] coshx = 32'd0;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [31:0] ieee_epx;
    logic [31:0] ieee_sinhx;
    logic [31:0] ieee_coshx;
    logic        out_stb;
    logic        out_ack = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fixed_to_ieee3 #(.FRAC_BITS(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_epx        (epx),
        .i_sinhx      (sinhx),
        .i_coshx      (coshx),
        .i_in_stb     (in_stb),
        .o_in_ack     (in_ack),
        .o_ieee_epx   (ieee_epx),
        .o_ieee_sinhx (ieee_sinhx),
        .o_ieee_coshx (ieee_coshx),
        .o_out_stb    (out_stb),
        .i_out_ack    (out_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Leading-one position of a nonzero magnitude.
    function automatic int msb_pos(input logic [63:0] m);
        int p;
        p = 0;
        for (int i = 0; i < 64; i++) begin
            if (m >= (64'd1 << i)) p = i;
        end
        return p;
    endfunction

    function automatic logic [63:0] magnitude(input logic [31:0] v);
        logic [63:0] m;
        m = {32'd0, v};
        if (v[31]) m = 64'h1_0000_0000 - m;
        return m;
    endfunction

    // Value v / 2^16 expressed as a float: 24 significant bits taken from the top of |v|.
    function automatic logic [31:0] ref_word(input logic [31:0] v);
        logic [63:0] m;
        logic [63:0] q;
        int          p;
        int          e;
`ifdef FIXED_TO_IEEE3_RNE_EN
        logic [63:0] rem;
        logic [63:0] half;
`endif
        if (v == 32'd0) return 32'd0;
        m = magnitude(v);
        p = msb_pos(m);
        e = p + 127 - 16;
        if (p > 23) begin
            q = m >> (p - 23);
`ifdef FIXED_TO_IEEE3_RNE_EN
            rem  = m - (q << (p - 23));
            half = 64'd1 << (p - 24);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
`endif
        end else begin
            q = m << (23 - p);
        end
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        return {v[31], e[7:0], q[22:0]};
    endfunction

    function automatic int ref_cycles(input logic [31:0] v);
        if (v == 32'd0) return 2;
        return 2 + 31 - msb_pos(magnitude(v));
    endfunction

    task automatic accept(input logic [31:0] e, input logic [31:0] s, input logic [31:0] c);
        int n;
        n = 0;
        while (!in_ack && n < 200) begin
            tick();
            n++;
        end
        check("in_ack_ready", {31'd0, in_ack}, 32'd1);
        epx    = e;
        sinhx  = s;
        coshx  = c;
        in_stb = 1'b1;
        tick();
        in_stb = 1'b0;
        check("in_ack_drop", {31'd0, in_ack}, 32'd0);
    endtask

    task automatic wait_out(input logic [31:0] e, input logic [31:0] s, input logic [31:0] c);
        int n;
        n = 0;
        while (!out_stb && n < 200) begin
            tick();
            n++;
        end
        check("latency", n, ref_cycles(e) + ref_cycles(s) + ref_cycles(c));
        check("ieee_epx", ieee_epx, ref_word(e));
        check("ieee_sinhx", ieee_sinhx, ref_word(s));
        check("ieee_coshx", ieee_coshx, ref_word(c));
        check("in_ack_busy", {31'd0, in_ack}, 32'd0);
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("out_stb_clear", {31'd0, out_stb}, 32'd0);
        check("in_ack_back", {31'd0, in_ack}, 32'd1);
    endtask

    task automatic convert(input logic [31:0] e, input logic [31:0] s, input logic [31:0] c);
        accept(e, s, c);
        wait_out(e, s, c);
        do_ack();
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r = 32'd0;
            1: r = r >> $urandom_range(1, 31);
            2: r = -(r >> $urandom_range(1, 31));
            3: r = {r[31], 31'd0} | (r & 32'h0000_01FF);
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] h_epx;
        logic [31:0] h_sinhx;
        logic [31:0] h_coshx;
        logic        stable;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ack", {31'd0, in_ack}, 32'd1);
        check("rst_out_stb", {31'd0, out_stb}, 32'd0);
        check("rst_epx", ieee_epx, 32'd0);
        check("rst_sinhx", ieee_sinhx, 32'd0);
        check("rst_coshx", ieee_coshx, 32'd0);

        // 1.0, 0, -2.5.
        accept(32'h0001_0000, 32'h0000_0000, 32'hFFFD_8000);
        wait_out(32'h0001_0000, 32'h0000_0000, 32'hFFFD_8000);
        check("lit_one", ieee_epx, 32'h3F80_0000);
        check("lit_zero", ieee_sinhx, 32'h0000_0000);
        check("lit_m2p5", ieee_coshx, 32'hC020_0000);
        do_ack();

        // Rounding carry, single-lsb input, large positive.
        convert(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_0000);
`ifdef FIXED_TO_IEEE3_RNE_EN
        check("lit_max_rne", ieee_epx, 32'h4700_0000);
`else
        check("lit_max_trunc", ieee_epx, 32'h46FF_FFFF);
`endif
        check("lit_lsb", ieee_sinhx, 32'h3780_0000);
        check("lit_7fff", ieee_coshx, 32'h46FF_FE00);

        // Most negative input.
        convert(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0080);
        check("lit_min", ieee_epx, 32'hC700_0000);

        // Back-pressure: hold off ack, try to inject a new sample.
        accept(32'h0003_0000, 32'hFFFF_0000, 32'h0000_4000);
        wait_out(32'h0003_0000, 32'hFFFF_0000, 32'h0000_4000);
        h_epx   = ieee_epx;
        h_sinhx = ieee_sinhx;
        h_coshx = ieee_coshx;
        stable  = 1'b1;
        epx     = 32'h1234_5678;
        sinhx   = 32'h8765_4321;
        coshx   = 32'h0F0F_0F0F;
        for (int i = 0; i < 10; i++) begin
            in_stb = (i == 3);
            tick();
            if (!out_stb || in_ack || ieee_epx !== h_epx || ieee_sinhx !== h_sinhx
                || ieee_coshx !== h_coshx) stable = 1'b0;
        end
        in_stb = 1'b0;
        check("stall_stable", {31'd0, stable}, 32'd1);
        check("stall_out_stb", {31'd0, out_stb}, 32'd1);
        do_ack();
        tick();
        check("no_queue_in_ack", {31'd0, in_ack}, 32'd1);
        check("no_queue_out_stb", {31'd0, out_stb}, 32'd0);

        // Reset during channel 1 normalisation.
        accept(32'h0000_0000, 32'h0000_0001, 32'h0001_0000);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ack", {31'd0, in_ack}, 32'd1);
        check("mid_rst_out_stb", {31'd0, out_stb}, 32'd0);
        check("mid_rst_epx", ieee_epx, 32'd0);
        check("mid_rst_sinhx", ieee_sinhx, 32'd0);
        check("mid_rst_coshx", ieee_coshx, 32'd0);
        convert(32'hFFFE_0000, 32'h0000_0001, 32'h0001_8001);

        // Random samples.
        for (int k = 0; k < 30; k++) begin
            convert(rand_val(), rand_val(), rand_val());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
